fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Front-end controller that generates fetch addresses, drives the instruction-cache request/response handshake and fills the dual-issue instruction FIFO with up to two instructions per cycle. It applies FIFO back-pressure, handles branch/exception redirects by flushing the FIFO, and discards any in-flight cache response that belongs to the old path. It sits between the PC/redirect logic of the execute stage and the instruction FIFO write port.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset (word aligned)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- redirect_valid  in  1  branch/exception redirect this cycle
- redirect_pc  in  32  new fetch address (word aligned)
- fifo_full  in  1  instruction FIFO cannot accept two more entries
- fifo_flush  out  1  clears the instruction FIFO
- fifo_write_en1 / fifo_write_en2  out  1 each  FIFO write enables (en2 only with en1)
- fifo_write_data1 / fifo_write_data2  out  32 each  instruction words
- fifo_write_address1 / fifo_write_address2  out  32 each  instruction PCs
- ic_req  out  1  cache request valid
- ic_addr  out  32  cache request address, 8-byte aligned (ic_addr[2:0]=0)
- ic_addr_ok  in  1  request accepted this cycle
- ic_data_ok  in  1  response valid this cycle
- ic_rdata  in  64  words {pc+4, pc} of the aligned doubleword

## Operation
- Registered fetch_pc; ic_addr = {fetch_pc[31:3],3'b0}.
- FSM states: IDLE, REQ, WAIT, DISCARD.
- IDLE: !fifo_full -> REQ; otherwise stay.
- REQ: ic_req=1, ic_addr held stable until ic_addr_ok. ic_addr_ok -> WAIT.
- WAIT: on ic_data_ok, capture the response into the write register. If fetch_pc[2]=0, write both words (pc, pc+4) and advance fetch_pc by 8. If fetch_pc[2]=1, write only the upper word as write 1 and advance by 4. Then REQ if !fifo_full, else IDLE.
- DISCARD: wait for ic_data_ok, drop the data, then REQ.
- Only one outstanding cache transaction at a time.
- Redirect, at most once per cycle: fetch_pc <= redirect_pc and fifo_flush=1 combinationally that cycle. Any pending FIFO write is suppressed that cycle.
  - IDLE or REQ without ic_addr_ok: next state REQ.
  - REQ with ic_addr_ok, or WAIT without ic_data_ok: next state DISCARD.
  - WAIT with ic_data_ok the same cycle: data dropped, next state REQ.
  - DISCARD with ic_data_ok: next state REQ; without it, stay in DISCARD.
- fifo_full is sampled only when deciding to issue. Full asserts with ≥2 free slots, so one response always fits.
- fetch_pc arithmetic is modulo 2^32; wrap from 32'hFFFF_FFF8 to 0 is legal.

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, ic_req=0, all fifo_write_* = 0, fifo_flush=1 while rst is high.
- ic_req rises the cycle after reset deasserts, if !fifo_full.
- FIFO write is registered: fifo_write_en* is high the cycle after ic_data_ok, for exactly one cycle.
- Back-to-back throughput: REQ(addr_ok) -> WAIT(data_ok), with the next REQ starting in the following cycle. Minimum 2 cycles per doubleword.
- rst mid-transaction aborts it. The I-cache shares the same rst, so no stale response arrives.

## Configuration
- FETCH_PERF_COUNTER_EN defined: adds 64-bit counters for fetch_requests, fetched_words, discarded_responses and full_stall_cycles. Counters clear on rst and are exposed on perf_* output ports.
- FETCH_PERF_COUNTER_EN undefined: the counters and perf_* ports are absent.
- Functional behaviour is identical either way.

## Structure
- Shared package frontend_pkg:
  - fetch_state_t enum (IDLE/REQ/WAIT/DISCARD)
  - FETCH_WIDTH=2
  - default RESET_PC constant
- One sub-module, fetch_pack: combinational split of the 64-bit response into the two FIFO write lanes from fetch_pc[2]. The FSM, PC register and write register stay in the top.

## Test plan
- Reset, RESET_PC=32'hBFC0_0000, cache returns data_ok 1 cycle after addr_ok -> FIFO receives the pairs (BFC0_0000,BFC0_0004), then (BFC0_0008,BFC0_000C), each with both write enables high.
- Redirect to 32'h8000_0104 while in WAIT -> fifo_flush pulses. The old response is dropped. Next ic_addr=8000_0100. Only the word at 8000_0104 is written, with en2=0. The next ic_addr is 8000_0108.
- Redirect in the same cycle as ic_data_ok -> no FIFO write follows, and ic_req rises the next cycle with the new address.
- fifo_full held high for 10 cycles from IDLE -> ic_req stays 0. Deasserting full raises ic_req 1 cycle later.
- ic_addr_ok withheld for 5 cycles in REQ -> ic_req and ic_addr remain stable throughout.
- fetch_pc=32'hFFFF_FFF8 -> the next request is ic_addr=0.

Source files
------------

// File: rtl/frontend_pkg.sv
// -----------------------------------------------------------------------------
// frontend_pkg
// Shared types and constants for the instruction fetch front end.
//   fetch_state_t    : fetch sequencer FSM states
//   FETCH_WIDTH      : instructions delivered to the FIFO per cache response
//   DEFAULT_RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------
package frontend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam int unsigned FETCH_WIDTH      = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Words actually usable from an aligned doubleword fetched at pc.
    function automatic logic [1:0] lane_count(input logic [31:0] pc);
        return pc[2] ? 2'd1 : 2'(FETCH_WIDTH);
    endfunction

endpackage

// File: rtl/fetch_pack.sv
// -----------------------------------------------------------------------------
// fetch_pack
// Combinational split of a 64-bit I-cache response into the two FIFO write
// lanes. The doubleword always holds {pc_aligned+4, pc_aligned}; when the
// fetch PC points at the upper word only that word is valid and it is
// presented on lane 1.
// Ports:
//   rdata        in  64  cache response {word @+4, word @+0}
//   pc           in  32  fetch PC the response belongs to (word aligned)
//   lane_data1   out 32  instruction for lane 1
//   lane_addr1   out 32  PC of lane 1
//   lane_data2   out 32  instruction for lane 2 (0 when invalid)
//   lane_addr2   out 32  PC of lane 2 (0 when invalid)
//   lane_en2     out 1   lane 2 carries a valid instruction
// -----------------------------------------------------------------------------
module fetch_pack
    import frontend_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [31:0] pc,
    output logic [31:0] lane_data1,
    output logic [31:0] lane_addr1,
    output logic [31:0] lane_data2,
    output logic [31:0] lane_addr2,
    output logic        lane_en2
);

    // NOTE: every output gets a default first so no path through the block
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        lane_data1 = rdata[31:0];
        lane_addr1 = pc;
        lane_data2 = rdata[63:32];
        lane_addr2 = pc + 32'd4;
        lane_en2   = (lane_count(pc) == 2'd2);
        if (pc[2]) begin
            lane_data1 = rdata[63:32];
            lane_data2 = 32'd0;
            lane_addr2 = 32'd0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Front-end fetch controller: generates fetch addresses, runs the I-cache
// request/response handshake (one transaction outstanding), and writes up to
// two instructions per response into the instruction FIFO. Redirects flush
// the FIFO and any in-flight response from the old path is discarded.
//
// Optional feature: define FETCH_PERF_COUNTER_EN to add 64-bit performance
// counters on perf_* ports. Functional behaviour is unchanged.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_valid/redirect_pc branch/exception redirect and target
//   fifo_full                  FIFO cannot take two more entries
//   fifo_flush                 clear FIFO (rst or redirect, combinational)
//   fifo_write_en1/en2         registered FIFO write enables
//   fifo_write_data1/data2     instruction words
//   fifo_write_address1/2      instruction PCs
//   ic_req/ic_addr             cache request, 8-byte aligned address
//   ic_addr_ok                 request accepted
//   ic_data_ok/ic_rdata        cache response
//   perf_*                     (FETCH_PERF_COUNTER_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_sequencer
    import frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fifo_full,
    output logic        fifo_flush,
    output logic        fifo_write_en1,
    output logic        fifo_write_en2,
    output logic [31:0] fifo_write_data1,
    output logic [31:0] fifo_write_data2,
    output logic [31:0] fifo_write_address1,
    output logic [31:0] fifo_write_address2,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_addr_ok,
    input  logic        ic_data_ok,
    input  logic [63:0] ic_rdata
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [63:0] perf_fetch_requests,
    output logic [63:0] perf_fetched_words,
    output logic [63:0] perf_discarded_responses,
    output logic [63:0] perf_full_stall_cycles
`endif
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;

    logic         wr_en1;
    logic         wr_en2;
    logic [31:0]  wr_data1;
    logic [31:0]  wr_data2;
    logic [31:0]  wr_addr1;
    logic [31:0]  wr_addr2;

    logic [31:0]  lane_data1;
    logic [31:0]  lane_addr1;
    logic [31:0]  lane_data2;
    logic [31:0]  lane_addr2;
    logic         lane_en2;

    logic         accept_data;
    logic [31:0]  pc_step;

    fetch_pack u_fetch_pack (
        .rdata      (ic_rdata),
        .pc         (fetch_pc),
        .lane_data1 (lane_data1),
        .lane_addr1 (lane_addr1),
        .lane_data2 (lane_data2),
        .lane_addr2 (lane_addr2),
        .lane_en2   (lane_en2)
    );

    // A response is kept only if it arrives in WAIT on an unredirected path.
    assign accept_data = (state == WAIT) && ic_data_ok && !redirect_valid;
    assign pc_step     = fetch_pc[2] ? 32'd4 : 32'd8;

    assign ic_req     = (state == REQ);
    assign ic_addr    = {fetch_pc[31:3], 3'b000};
    assign fifo_flush = rst || redirect_valid;

    // A write registered last cycle is squashed if a redirect flushes the
    // FIFO in the same cycle; it belongs to the abandoned path.
    assign fifo_write_en1      = wr_en1 && !redirect_valid;
    assign fifo_write_en2      = wr_en2 && !redirect_valid;
    assign fifo_write_data1    = wr_data1;
    assign fifo_write_data2    = wr_data2;
    assign fifo_write_address1 = wr_addr1;
    assign fifo_write_address2 = wr_addr2;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            wr_en1   <= 1'b0;
            wr_en2   <= 1'b0;
            // NOTE: the write data/address registers are reset too, because
            // the FIFO write bus is required to read zero out of reset.
            wr_data1 <= 32'd0;
            wr_data2 <= 32'd0;
            wr_addr1 <= 32'd0;
            wr_addr2 <= 32'd0;
        end else begin
            wr_en1 <= 1'b0;
            wr_en2 <= 1'b0;

            if (accept_data) begin
                wr_en1   <= 1'b1;
                wr_en2   <= lane_en2;
                wr_data1 <= lane_data1;
                wr_data2 <= lane_data2;
                wr_addr1 <= lane_addr1;
                wr_addr2 <= lane_addr2;
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                unique case (state)
                    IDLE:    state <= REQ;
                    REQ:     state <= ic_addr_ok ? DISCARD : REQ;
                    WAIT:    state <= ic_data_ok ? REQ : DISCARD;
                    DISCARD: state <= ic_data_ok ? REQ : DISCARD;
                    default: state <= IDLE;
                endcase
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!fifo_full) state <= REQ;
                    end
                    REQ: begin
                        if (ic_addr_ok) state <= WAIT;
                    end
                    WAIT: begin
                        if (ic_data_ok) begin
                            fetch_pc <= fetch_pc + pc_step;
                            state    <= fifo_full ? IDLE : REQ;
                        end
                    end
                    DISCARD: begin
                        if (ic_data_ok) state <= REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [1:0] words_written;

    assign words_written = 2'(fifo_write_en1) + 2'(fifo_write_en2);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_requests      <= 64'd0;
            perf_fetched_words       <= 64'd0;
            perf_discarded_responses <= 64'd0;
            perf_full_stall_cycles   <= 64'd0;
        end else begin
            if (ic_req && ic_addr_ok)
                perf_fetch_requests <= perf_fetch_requests + 64'd1;
            perf_fetched_words <= perf_fetched_words + 64'(words_written);
            if (ic_data_ok && ((state == DISCARD) ||
                               ((state == WAIT) && redirect_valid)))
                perf_discarded_responses <= perf_discarded_responses + 64'd1;
            if ((state == IDLE) && fifo_full && !redirect_valid)
                perf_full_stall_cycles <= perf_full_stall_cycles + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed, self-checking bench for fetch_sequencer. The I-cache handshake is
// driven by hand from each scenario task; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        fifo_flush;
    logic        fifo_write_en1;
    logic        fifo_write_en2;
    logic [31:0] fifo_write_data1;
    logic [31:0] fifo_write_data2;
    logic [31:0] fifo_write_address1;
    logic [31:0] fifo_write_address2;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_addr_ok;
    logic        ic_data_ok;
    logic [63:0] ic_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .fifo_full           (fifo_full),
        .fifo_flush          (fifo_flush),
        .fifo_write_en1      (fifo_write_en1),
        .fifo_write_en2      (fifo_write_en2),
        .fifo_write_data1    (fifo_write_data1),
        .fifo_write_data2    (fifo_write_data2),
        .fifo_write_address1 (fifo_write_address1),
        .fifo_write_address2 (fifo_write_address2),
        .ic_req              (ic_req),
        .ic_addr             (ic_addr),
        .ic_addr_ok          (ic_addr_ok),
        .ic_data_ok          (ic_data_ok),
        .ic_rdata            (ic_rdata)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request accepted immediately, response one cycle later. Returns just
    // after the data_ok edge with both handshake inputs low.
    task automatic do_txn(input logic [63:0] rdata);
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        ic_data_ok = 1'b1;
        ic_rdata   = rdata;
        tick();
        ic_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        fifo_full = 1'b0; ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = 64'd0;
        repeat (3) tick();
        total_cnt++;
        if ({ic_req, fifo_flush, fifo_write_en1, fifo_write_en2} !== 4'b0100)
            $display("FAIL reset_ctrl: got req/flush/en1/en2=%b want 0100",
                     {ic_req, fifo_flush, fifo_write_en1, fifo_write_en2});
        else pass_cnt++;
        total_cnt++;
        if (ic_addr !== 32'hBFC0_0000 || fifo_write_address1 !== 32'd0 ||
            fifo_write_data1 !== 32'd0)
            $display("FAIL reset_addr: got ic_addr=%h wa1=%h wd1=%h want bfc00000 0 0",
                     ic_addr, fifo_write_address1, fifo_write_data1);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (ic_req !== 1'b0 || fifo_flush !== 1'b0)
            $display("FAIL reset_release: got req=%b flush=%b want 0 0", ic_req, fifo_flush);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'hBFC0_0000)
            $display("FAIL first_req: got req=%b addr=%h want 1 bfc00000", ic_req, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_txn({32'hA000_0004, 32'hA000_0000});
        total_cnt++;
        if ({fifo_write_en1, fifo_write_en2} !== 2'b11 ||
            fifo_write_address1 !== 32'hBFC0_0000 || fifo_write_address2 !== 32'hBFC0_0004 ||
            fifo_write_data1 !== 32'hA000_0000 || fifo_write_data2 !== 32'hA000_0004)
            $display("FAIL pair0: got en=%b a1=%h a2=%h d1=%h d2=%h want 11 bfc00000 bfc00004 a0000000 a0000004",
                     {fifo_write_en1, fifo_write_en2}, fifo_write_address1,
                     fifo_write_address2, fifo_write_data1, fifo_write_data2);
        else pass_cnt++;
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'hBFC0_0008)
            $display("FAIL b2b_req: got req=%b addr=%h want 1 bfc00008", ic_req, ic_addr);
        else pass_cnt++;
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        total_cnt++;
        if (fifo_write_en1 !== 1'b0 || ic_req !== 1'b0)
            $display("FAIL one_cycle_write: got en1=%b req=%b want 0 0", fifo_write_en1, ic_req);
        else pass_cnt++;
        ic_data_ok = 1'b1;
        ic_rdata   = {32'hA000_000C, 32'hA000_0008};
        tick();
        ic_data_ok = 1'b0;
        total_cnt++;
        if ({fifo_write_en1, fifo_write_en2} !== 2'b11 ||
            fifo_write_address1 !== 32'hBFC0_0008 || fifo_write_address2 !== 32'hBFC0_000C ||
            fifo_write_data1 !== 32'hA000_0008 || fifo_write_data2 !== 32'hA000_000C)
            $display("FAIL pair1: got en=%b a1=%h a2=%h d1=%h d2=%h want 11 bfc00008 bfc0000c a0000008 a000000c",
                     {fifo_write_en1, fifo_write_en2}, fifo_write_address1,
                     fifo_write_address2, fifo_write_data1, fifo_write_data2);
        else pass_cnt++;
    endtask

    // Enters with a request pending at BFC0_0010.
    task automatic test_redirect_wait();
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0104;
        #1;
        total_cnt++;
        if (fifo_flush !== 1'b1)
            $display("FAIL redir_flush: got flush=%b want 1", fifo_flush);
        else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (fifo_flush !== 1'b0 || ic_req !== 1'b0)
            $display("FAIL discard_state: got flush=%b req=%b want 0 0", fifo_flush, ic_req);
        else pass_cnt++;
        ic_data_ok = 1'b1;
        ic_rdata   = {32'hDEAD_0014, 32'hDEAD_0010};
        tick();
        ic_data_ok = 1'b0;
        total_cnt++;
        if (fifo_write_en1 !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'h8000_0100)
            $display("FAIL discard_drop: got en1=%b req=%b addr=%h want 0 1 80000100",
                     fifo_write_en1, ic_req, ic_addr);
        else pass_cnt++;
        do_txn({32'hB000_0104, 32'hB000_0100});
        total_cnt++;
        if ({fifo_write_en1, fifo_write_en2} !== 2'b10 ||
            fifo_write_address1 !== 32'h8000_0104 || fifo_write_data1 !== 32'hB000_0104)
            $display("FAIL odd_word: got en=%b a1=%h d1=%h want 10 80000104 b0000104",
                     {fifo_write_en1, fifo_write_en2}, fifo_write_address1, fifo_write_data1);
        else pass_cnt++;
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h8000_0108)
            $display("FAIL odd_next: got req=%b addr=%h want 1 80000108", ic_req, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect_data_ok();
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok     = 1'b0;
        ic_data_ok     = 1'b1;
        ic_rdata       = {32'hDEAD_010C, 32'hDEAD_0108};
        redirect_valid = 1'b1;
        redirect_pc    = 32'h9000_0000;
        tick();
        ic_data_ok     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (fifo_write_en1 !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'h9000_0000)
            $display("FAIL redir_dataok: got en1=%b req=%b addr=%h want 0 1 90000000",
                     fifo_write_en1, ic_req, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_full_stall();
        int bad = 0;
        fifo_full = 1'b1;
        do_txn({32'hC000_0004, 32'hC000_0000});
        total_cnt++;
        if (fifo_write_en1 !== 1'b1 || fifo_write_address1 !== 32'h9000_0000 || ic_req !== 1'b0)
            $display("FAIL full_idle: got en1=%b a1=%h req=%b want 1 90000000 0",
                     fifo_write_en1, fifo_write_address1, ic_req);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ic_req !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL full_hold: got %0d cycles with req=1 want 0", bad);
        else pass_cnt++;
        fifo_full = 1'b0;
        #1;
        total_cnt++;
        if (ic_req !== 1'b0)
            $display("FAIL full_release_same: got req=%b want 0", ic_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h9000_0008)
            $display("FAIL full_release: got req=%b addr=%h want 1 90000008", ic_req, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_addr_ok_stall();
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ic_req !== 1'b1 || ic_addr !== 32'h9000_0008) bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL req_stable: got %0d unstable cycles want 0", bad);
        else pass_cnt++;
        do_txn({32'hC000_000C, 32'hC000_0008});
        total_cnt++;
        if ({fifo_write_en1, fifo_write_en2} !== 2'b11 || fifo_write_address2 !== 32'h9000_000C ||
            ic_addr !== 32'h9000_0010)
            $display("FAIL stall_txn: got en=%b a2=%h addr=%h want 11 9000000c 90000010",
                     {fifo_write_en1, fifo_write_en2}, fifo_write_address2, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'hFFFF_FFF8)
            $display("FAIL wrap_req: got req=%b addr=%h want 1 fffffff8", ic_req, ic_addr);
        else pass_cnt++;
        do_txn({32'hE000_0004, 32'hE000_0000});
        total_cnt++;
        if ({fifo_write_en1, fifo_write_en2} !== 2'b11 || fifo_write_address2 !== 32'hFFFF_FFFC ||
            ic_req !== 1'b1 || ic_addr !== 32'h0000_0000)
            $display("FAIL wrap_next: got en=%b a2=%h req=%b addr=%h want 11 fffffffc 1 00000000",
                     {fifo_write_en1, fifo_write_en2}, fifo_write_address2, ic_req, ic_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ic_addr_ok = 1'b1;
        tick();
        ic_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (ic_req !== 1'b0 || fifo_flush !== 1'b1 || ic_addr !== 32'hBFC0_0000)
            $display("FAIL reset_mid: got req=%b flush=%b addr=%h want 0 1 bfc00000",
                     ic_req, fifo_flush, ic_addr);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (ic_req !== 1'b1 || ic_addr !== 32'hBFC0_0000)
            $display("FAIL reset_mid_restart: got req=%b addr=%h want 1 bfc00000", ic_req, ic_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_data_ok();
        test_full_stall();
        test_addr_ok_stall();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
